// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side FIFO between a UART receiver and a bus read port. The
//   receiver pushes one entry per received byte, with its framing-error flag
//   stored alongside. The bus side reads the head entry
//   first-word-fall-through and removes it with pop.
//
// Parameters
//   DEPTH   entry count, a power of two, >= 2
//   WIDTH   data bits per entry
//
// Ports
//   clk           in   single clock, rising edge
//   nReset        in   asynchronous active-low reset
//   push          in   write strobe (receiver done pulse)
//   push_data     in   received data, sampled with push
//   push_err      in   framing-error flag for push_data
//   pop           in   removes the head entry
//   pop_data      out  head entry data (0 when empty)
//   pop_err       out  head entry error flag (0 when empty)
//   empty         out  count == 0
//   full          out  count == DEPTH
//   count         out  number of stored entries
//   overflow      out  sticky: a push was dropped because the FIFO was full
//   clr_overflow  in   clears overflow (a same-cycle drop wins)
//   flush         in   discards all entries; overrides push/pop
//
// Optional build macro UART_RX_FIFO_WATERMARK_EN adds:
//   level         in   watermark threshold (0 disables irq)
//   irq           out  registered: high the cycle after count >= level
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       push_err,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       pop_err,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_overflow,
`ifdef UART_RX_FIFO_WATERMARK_EN
    input  logic [$clog2(DEPTH):0]     level,
    output logic                       irq,
`endif
    input  logic                       flush
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Each entry holds the error flag in the MSB above the data.
    logic [WIDTH:0]    mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic              pushAccept;
    logic              pushDrop;
    logic              popAccept;
    logic [CW-1:0]     countNext;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still takes the
    // push. Pop on empty is ignored, which also makes push+pop on empty a
    // plain push.
    assign popAccept  = pop && !empty;
    assign pushAccept = push && (!full || pop);
    assign pushDrop   = push && full && !pop;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        countNext = count;
        case ({pushAccept, popAccept})
            2'b10:   countNext = count + CW'(1);
            2'b01:   countNext = count - CW'(1);
            default: countNext = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are AW bits wide with DEPTH a power of two, so the
            // increment wraps DEPTH-1 -> 0 on its own.
            if (pushAccept) wrPtr <= wrPtr + AW'(1);
            if (popAccept)  rdPtr <= rdPtr + AW'(1);
            count <= countNext;
            if (pushDrop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale contents are
    // never visible because the read port is masked by empty.
    always_ff @(posedge clk) begin
        if (pushAccept && !flush)
            mem[wrPtr] <= {push_err, push_data};
    end

    assign pop_data = empty ? '0   : mem[rdPtr][WIDTH-1:0];
    assign pop_err  = empty ? 1'b0 : mem[rdPtr][WIDTH];

`ifdef UART_RX_FIFO_WATERMARK_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            irq <= 1'b0;
        else
            irq <= (level != '0) && (count >= level);
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo (DEPTH=16, WIDTH=8).
//   Inputs change 1 ns after a rising edge; outputs are compared there too.
//   Watermark checks compile in when UART_RX_FIFO_WATERMARK_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk;
    logic       nReset;
    logic       push;
    logic [7:0] push_data;
    logic       push_err;
    logic       pop;
    logic [7:0] pop_data;
    logic       pop_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_overflow;
    logic       flush;
`ifdef UART_RX_FIFO_WATERMARK_EN
    logic [4:0] level;
    logic       irq;
`endif

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk          (clk),
        .nReset       (nReset),
        .push         (push),
        .push_data    (push_data),
        .push_err     (push_err),
        .pop          (pop),
        .pop_data     (pop_data),
        .pop_err      (pop_err),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
`ifdef UART_RX_FIFO_WATERMARK_EN
        .level        (level),
        .irq          (irq),
`endif
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doPush(input logic [7:0] d, input logic e);
        push = 1'b1; push_data = d; push_err = e;
        cycle();
        push = 1'b0; push_err = 1'b0;
    endtask

    task automatic doPop();
        pop = 1'b1;
        cycle();
        pop = 1'b0;
    endtask

    task automatic doFlush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        nReset = 1'b0; push = 1'b0; push_data = '0; push_err = 1'b0;
        pop = 1'b0; clr_overflow = 1'b0; flush = 1'b0;
`ifdef UART_RX_FIFO_WATERMARK_EN
        level = 5'd4;
`endif
        #3;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_pop_err", pop_err, 0);
        @(posedge clk); #1;
        nReset = 1'b1;
        cycle();

        // Basic ordering: 0x41, 0x42, 0x43.
        doPush(8'h41, 1'b0);
        doPush(8'h42, 1'b0);
        doPush(8'h43, 1'b0);
        check("abc_count", count, 3);
        check("abc_head", pop_data, 8'h41);
        for (int i = 0; i < 3; i++) begin
            check("abc_pop_data", pop_data, 8'h41 + i);
            doPop();
        end
        check("abc_empty", empty, 1);

        // Pop while empty is ignored.
        doPop();
        check("pop_empty_count", count, 0);
        check("pop_empty_flag", empty, 1);

        // 17 pushes into 16 entries: last one dropped.
        for (int i = 0; i < 17; i++) doPush(8'(i), 1'b0);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            check("ovf_pop_data", pop_data, i);
            doPop();
        end
        check("ovf_drained", empty, 1);
        check("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1; cycle(); clr_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) doPush(8'h20 + 8'(i), 1'b0);
        check("fpp_full_before", full, 1);
        push = 1'b1; push_data = 8'hAA; pop = 1'b1;
        cycle();
        push = 1'b0; pop = 1'b0;
        check("fpp_count", count, 16);
        check("fpp_overflow", overflow, 0);
        for (int i = 1; i < 16; i++) begin
            check("fpp_pop_data", pop_data, 8'h20 + i);
            doPop();
        end
        check("fpp_16th", pop_data, 8'hAA);
        doPop();
        check("fpp_empty", empty, 1);

        // Empty with simultaneous push and pop: push only.
        push = 1'b1; push_data = 8'h55; push_err = 1'b1; pop = 1'b1;
        cycle();
        push = 1'b0; push_err = 1'b0; pop = 1'b0;
        check("epp_count", count, 1);
        check("epp_data", pop_data, 8'h55);
        check("epp_err", pop_err, 1);
        doPop();
        check("epp_empty", empty, 1);
        check("epp_err_masked", pop_err, 0);

        // 20 push/pop pairs, crossing the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            doPush(8'h60 + 8'(i), i[0]);
            check("alt_data", pop_data, 8'h60 + i);
            check("alt_err", pop_err, i[0]);
            doPop();
        end
        check("alt_empty", empty, 1);

        // Flush with simultaneous push and pop.
        doPush(8'h90, 1'b0);
        doPush(8'h91, 1'b0);
        check("fl_count_before", count, 2);
        flush = 1'b1; push = 1'b1; push_data = 8'h92; pop = 1'b1;
        cycle();
        flush = 1'b0; push = 1'b0; pop = 1'b0;
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_pop_data", pop_data, 0);
        doPush(8'h93, 1'b0);
        check("fl_after_push", pop_data, 8'h93);
        check("fl_after_count", count, 1);
        doFlush();

        // Overflow set wins over clr_overflow; flush clears overflow.
        for (int i = 0; i < 16; i++) doPush(8'(i), 1'b0);
        push = 1'b1; push_data = 8'hEE; clr_overflow = 1'b1;
        cycle();
        push = 1'b0; clr_overflow = 1'b0;
        check("prio_overflow", overflow, 1);
        check("prio_head", pop_data, 8'h00);
        doFlush();
        check("flush_clr_ovf", overflow, 0);
        check("flush_clr_full", full, 0);

        // Watermark build: irq one cycle after count reaches level.
        for (int i = 0; i < 4; i++) doPush(8'hB0 + 8'(i), 1'b0);
        check("wm_count", count, 4);
`ifdef UART_RX_FIFO_WATERMARK_EN
        check("wm_irq_lag", irq, 0);
        cycle();
        check("wm_irq_set", irq, 1);
        doPop();
        check("wm_pop_count", count, 3);
        cycle();
        check("wm_irq_clear", irq, 0);
        doPush(8'hB4, 1'b0);
        cycle();
        check("wm_irq_again", irq, 1);
`endif

        // Reset asserted mid-cycle with a push in progress.
        push = 1'b1; push_data = 8'h77;
        #2;
        nReset = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_overflow", overflow, 0);
`ifdef UART_RX_FIFO_WATERMARK_EN
        check("mid_rst_irq", irq, 0);
`endif
        push = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_hold", count, 0);
        nReset = 1'b1;
        cycle();
        check("post_rst_empty", empty, 1);
        doPush(8'h78, 1'b1);
        check("post_rst_data", pop_data, 8'h78);
        check("post_rst_err", pop_err, 1);
        check("post_rst_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
